// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
package adder_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_STAGES = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } add_op_e;

  // Two's-complement overflow from the operand and result sign bits.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/slice_adder.sv
// Combinational W-bit ripple-carry adder used for one pipeline slice.
module slice_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic c;

  always_comb begin
    sum = '0;
    c   = cin;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract: one W-bit slice per stage, carry registered
// between stages, single global enable driven by the output handshake.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int W = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH) begin : g_chk_range
    $error("pipelined_adder: STAGES must be in 1..WIDTH");
  end
  if (WIDTH % STAGES != 0) begin : g_chk_div
    $error("pipelined_adder: WIDTH must be a multiple of STAGES");
  end

  add_op_e          op;
  logic             en;
  logic             push;
  logic [WIDTH-1:0] b_prime;
  logic             c0;

  assign op       = in_sub ? OP_SUB : OP_ADD;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign push     = in_valid && en;
  assign b_prime  = (op == OP_SUB) ? ~in_b : in_b;
  assign c0       = (op == OP_SUB) ? 1'b1 : in_cin;

  // Each stage consumes the low slice of the operands it receives and forwards
  // only the still-unadded upper part, so every register bit has a consumer.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int RIN = WIDTH - k * W;

    logic [RIN-1:0]     a_in;
    logic [RIN-1:0]     b_in;
    logic               c_in;
    logic               v_in;
    logic [W-1:0]       s_slice;
    logic               c_out;
    logic [(k+1)*W-1:0] sum_nxt;
    logic [(k+1)*W-1:0] sum_q;
    logic               c_q;
    logic               v_q;

    slice_adder #(.W(W)) u_slice (
      .a    (a_in[W-1:0]),
      .b    (b_in[W-1:0]),
      .cin  (c_in),
      .sum  (s_slice),
      .cout (c_out)
    );

    if (k == 0) begin : g_src
      assign a_in    = in_a;
      assign b_in    = b_prime;
      assign c_in    = c0;
      assign v_in    = push;
      assign sum_nxt = s_slice;
    end else begin : g_src
      assign a_in    = g_st[k-1].g_rem.ra_q;
      assign b_in    = g_st[k-1].g_rem.rb_q;
      assign c_in    = g_st[k-1].c_q;
      assign v_in    = g_st[k-1].v_q;
      assign sum_nxt = {s_slice, g_st[k-1].sum_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (en) begin
        v_q   <= v_in;
        c_q   <= c_out;
        sum_q <= sum_nxt;
      end
    end

    if (k < STAGES - 1) begin : g_rem
      logic [RIN-W-1:0] ra_q;
      logic [RIN-W-1:0] rb_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ra_q <= '0;
          rb_q <= '0;
        end else if (en) begin
          ra_q <= a_in[RIN-1:W];
          rb_q <= b_in[RIN-1:W];
        end
      end
    end else begin : g_last
      logic ovf_q;

      // The top slice holds the sign bits, so overflow is resolved here.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= signed_ovf(a_in[W-1], b_in[W-1], s_slice[W-1]);
        end
      end
    end
  end

  assign out_valid = g_st[STAGES-1].v_q;
  assign out_sum   = g_st[STAGES-1].sum_q;
  assign out_cout  = g_st[STAGES-1].c_q;
  assign out_ovf   = g_st[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: three depths (4, 1, 16) share one stimulus stream
// and each is scored against an integer-arithmetic reference queue.
module tb_pipelined_adder;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    int          acc;
    int          id;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv, ord, icin, isub;
  logic [15:0] ia, ib;
  logic [2:0]  ir, ov, oc, oo;
  logic [15:0] os [3];

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   next_id = 0;
  int   seen_id [3] = '{-1, -1, -1};
  bit   lat_chk = 1'b1;
  txn_t q [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_adder #(.WIDTH(16), .STAGES(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir[0]), .in_a(ia), .in_b(ib),
    .in_cin(icin), .in_sub(isub), .out_valid(ov[0]), .out_ready(ord),
    .out_sum(os[0]), .out_cout(oc[0]), .out_ovf(oo[0]));

  pipelined_adder #(.WIDTH(16), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir[1]), .in_a(ia), .in_b(ib),
    .in_cin(icin), .in_sub(isub), .out_valid(ov[1]), .out_ready(ord),
    .out_sum(os[1]), .out_cout(oc[1]), .out_ovf(oo[1]));

  pipelined_adder #(.WIDTH(16), .STAGES(16)) u_s16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir[2]), .in_a(ia), .in_b(ib),
    .in_cin(icin), .in_sub(isub), .out_valid(ov[2]), .out_ready(ord),
    .out_sum(os[2]), .out_cout(oc[2]), .out_ovf(oo[2]));

  function automatic int stg(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  // Reference: {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [15:0] bp;
    logic        c;
    int unsigned u;
    int          s;
    bp = sub ? ~b : b;
    c  = sub ? 1'b1 : cin;
    u  = 32'(a) + 32'(bp) + 32'(c);
    s  = int'($signed(a)) + int'($signed(bp)) + int'(c);
    return {(s > 32767 || s < -32768), u[16], u[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    txn_t        t;
    logic [17:0] e;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        q[i].delete();
        chk($sformatf("reset_valid_s%0d", stg(i)), 32'(ov[i]), 32'd0);
        chk($sformatf("reset_sum_s%0d", stg(i)), 32'(os[i]), 32'd0);
      end else begin
        chk($sformatf("in_ready_s%0d", stg(i)), 32'(ir[i]), 32'(!(ov[i] && !ord)));
        if (ov[i]) begin
          if (q[i].size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL spurious_out_s%0d: got out_valid=1 sum=%h, required no output", stg(i), os[i]);
          end else begin
            t = q[i][0];
            e = model(t.a, t.b, t.cin, t.sub);
            chk($sformatf("sum_s%0d_id%0d", stg(i), t.id), 32'(os[i]), 32'(e[15:0]));
            chk($sformatf("cout_s%0d_id%0d", stg(i), t.id), 32'(oc[i]), 32'(e[16]));
            chk($sformatf("ovf_s%0d_id%0d", stg(i), t.id), 32'(oo[i]), 32'(e[17]));
            if (t.id != seen_id[i]) begin
              seen_id[i] = t.id;
              if (lat_chk) chk($sformatf("latency_s%0d_id%0d", stg(i), t.id), 32'(cyc - t.acc), 32'(stg(i) - 1));
            end
            if (ord) void'(q[i].pop_front());
          end
        end
        if (iv && ir[i]) begin
          q[i].push_back('{a: ia, b: ib, cin: icin, sub: isub, acc: cyc + 1, id: next_id});
          next_id++;
        end
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    bit acc;
    acc  = 1'b0;
    iv   = 1'b1;
    ia   = a;
    ib   = b;
    icin = cin;
    isub = sub;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      acc = ir[0] && rst_n;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    iv = 1'b0;
    chk("send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic rnd_send(input bit allow_sub);
    send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
         allow_sub ? 1'($urandom_range(0, 1)) : 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One isolated operation with hand-computed expectations on every depth.
  task automatic single(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub,
                        input logic [15:0] es, input logic ec, input logic eo);
    int          lat [3];
    logic [15:0] gs [3];
    logic        gc [3];
    logic        go [3];
    bit          f [3];
    for (int i = 0; i < 3; i++) begin
      f[i] = 1'b0; lat[i] = 0; gs[i] = '0; gc[i] = 1'b0; go[i] = 1'b0;
    end
    send(a, b, cin, sub);
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!f[i] && ov[i]) begin
          f[i] = 1'b1; lat[i] = n + 1; gs[i] = os[i]; gc[i] = oc[i]; go[i] = oo[i];
        end
      end
      if (f[0] && f[1] && f[2]) break;
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("lit_seen_s%0d_%h", stg(i), a), 32'(f[i]), 32'd1);
      if (f[i]) begin
        chk($sformatf("lit_latency_s%0d_%h", stg(i), a), 32'(lat[i]), 32'(stg(i)));
        chk($sformatf("lit_sum_s%0d_%h", stg(i), a), 32'(gs[i]), 32'(es));
        chk($sformatf("lit_cout_s%0d_%h", stg(i), a), 32'(gc[i]), 32'(ec));
        chk($sformatf("lit_ovf_s%0d_%h", stg(i), a), 32'(go[i]), 32'(eo));
      end
    end
    idle(20);
  endtask

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got still running at %0t, required finished", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] edge_a [6] = '{16'h8000, 16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000};
    logic [15:0] edge_b [6] = '{16'h0001, 16'h8000, 16'hFFFF, 16'h8000, 16'hFFFF, 16'h0000};
    logic        edge_s [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b1; iv = 1'b0; ord = 1'b1; ia = '0; ib = '0; icin = 1'b0; isub = 1'b0;
    #2 rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    single(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    single(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    single(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) rnd_send(1'b0);
    idle(25);

    lat_chk = 1'b0;
    fork
      for (int i = 0; i < 8; i++) rnd_send(1'b1);
      begin
        idle(5);
        ord = 1'b0;
        idle(5);
        ord = 1'b1;
      end
    join
    idle(25);
    lat_chk = 1'b1;

    for (int i = 0; i < 6; i++) send(edge_a[i], edge_b[i], 1'b1, edge_s[i]);
    for (int i = 0; i < 16; i++) rnd_send(1'b1);
    idle(25);

    for (int i = 0; i < 3; i++) rnd_send(1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("async_reset_valid_s%0d", stg(i)), 32'(ov[i]), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    single(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) chk($sformatf("drained_s%0d", stg(i)), 32'(q[i].size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
